// File: rtl/hidden_layer_pkg.sv
// Shared constants, FSM state encoding and saturation helper for the hidden-layer backward pass.
// Latency: n/a (package).
// Backpressure: n/a (package).
package hidden_layer_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_UPD,
        ST_RESP
    } state_t;

    // Clamp a wide signed value into the range of a w-bit two's complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/grad_step_sat.sv
// Gradient step: shift product by the learning rate, optionally clip (GRAD_CLIP_EN), subtract, saturate.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module grad_step_sat #(
    parameter int DATA_W   = 16,
    parameter int LR_SHIFT = 12,
    parameter int CLIP_MAX = 1024
) (
    input  logic signed [2*DATA_W-1:0] prod,
    input  logic signed [DATA_W-1:0]   cur,
    output logic signed [DATA_W-1:0]   result
);
    import hidden_layer_pkg::*;

`ifdef GRAD_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic signed [63:0] CLIP_HI = 64'(CLIP_MAX);
    localparam logic signed [63:0] CLIP_LO = -CLIP_HI;

    logic signed [63:0] step;
    logic signed [63:0] step_c;
    logic signed [63:0] diff;

    always_comb begin
        step   = $signed({{(64-2*DATA_W){prod[2*DATA_W-1]}}, prod}) >>> LR_SHIFT;
        step_c = step;
        if (CLIP_EN && (step > CLIP_HI)) begin
            step_c = CLIP_HI;
        end else if (CLIP_EN && (step < CLIP_LO)) begin
            step_c = CLIP_LO;
        end
        // Subtract at full width so the saturation sees the true result.
        diff   = $signed({{(64-DATA_W){cur[DATA_W-1]}}, cur}) - step_c;
        result = DATA_W'(saturate(diff, DATA_W));
    end

endmodule

// File: rtl/hidden_layer_backprop.sv
// Hidden-layer backward pass: w <- w - lr*(act*err) into a weight/bias store, with a forward read port.
// Latency: result valid 3 cycles after the accept cycle; issue interval 4 cycles.
// Backpressure: result held in RESP until out_ready; in_ready only in IDLE. Optional GRAD_CLIP_EN.
module hidden_layer_backprop #(
    parameter int  DATA_W    = 16,
    parameter int  N_WEIGHTS = 16,
    parameter int  LR_SHIFT  = 12,
    parameter int  CLIP_MAX  = 1024,
    localparam int IDX_W     = $clog2(N_WEIGHTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_act,
    input  logic [DATA_W-1:0] in_err,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_weight,
    output logic [DATA_W-1:0] out_bias,
    output logic              busy,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_weight
);
    import hidden_layer_pkg::*;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0]          idx_q;
    logic signed [DATA_W-1:0]  act_q;
    logic signed [DATA_W-1:0]  err_q;
    logic                      last_q;
    logic signed [2*DATA_W-1:0] prod_q;
    logic signed [2*DATA_W-1:0] bias_prod;
    logic signed [DATA_W-1:0]  weights [N_WEIGHTS];
    logic signed [DATA_W-1:0]  bias_q;
    logic signed [DATA_W-1:0]  cur_w;
    logic signed [DATA_W-1:0]  w_new;
    logic signed [DATA_W-1:0]  b_new;
    logic                      idx_ok;

    // Index width can exceed the store when N_WEIGHTS is not a power of two.
    assign idx_ok    = (int'(idx_q) < N_WEIGHTS);
    assign cur_w     = idx_ok ? weights[idx_q] : '0;
    assign bias_prod = $signed({{DATA_W{err_q[DATA_W-1]}}, err_q}) <<< FRAC_W;
    assign rd_weight = (int'(rd_idx) < N_WEIGHTS) ? weights[rd_idx] : '0;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    grad_step_sat #(
        .DATA_W   (DATA_W),
        .LR_SHIFT (LR_SHIFT),
        .CLIP_MAX (CLIP_MAX)
    ) u_weight_step (
        .prod   (prod_q),
        .cur    (cur_w),
        .result (w_new)
    );

    grad_step_sat #(
        .DATA_W   (DATA_W),
        .LR_SHIFT (LR_SHIFT),
        .CLIP_MAX (CLIP_MAX)
    ) u_bias_step (
        .prod   (bias_prod),
        .cur    (bias_q),
        .result (b_new)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_MUL;
            ST_MUL:  state_nxt = ST_UPD;
            ST_UPD:  state_nxt = ST_RESP;
            ST_RESP: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx_q      <= '0;
            act_q      <= '0;
            err_q      <= '0;
            last_q     <= 1'b0;
            prod_q     <= '0;
            bias_q     <= '0;
            out_idx    <= '0;
            out_weight <= '0;
            out_bias   <= '0;
            for (int i = 0; i < N_WEIGHTS; i++) begin
                weights[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        idx_q  <= in_idx;
                        act_q  <= $signed(in_act);
                        err_q  <= $signed(in_err);
                        last_q <= in_last;
                    end
                end
                ST_MUL: begin
                    prod_q <= (2*DATA_W)'(act_q) * (2*DATA_W)'(err_q);
                end
                ST_UPD: begin
                    if (idx_ok) begin
                        weights[idx_q] <= w_new;
                    end
                    if (last_q) begin
                        bias_q <= b_new;
                    end
                    out_idx    <= idx_q;
                    out_weight <= idx_ok ? w_new : '0;
                    out_bias   <= last_q ? b_new : bias_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_layer_backprop.sv
// Directed bench for hidden_layer_backprop with a 12-entry store (non power of two).
// Expected values are hand computed in Q8.8 with LR_SHIFT=12.
module tb_hidden_layer_backprop;

    localparam int DW = 16;
    localparam int NW = 12;
    localparam int IW = 4;

`ifdef GRAD_CLIP_EN
    localparam logic [15:0] NEG_SAT = 16'hFC00;
    localparam logic [15:0] POS_SAT = 16'h0400;
`else
    localparam logic [15:0] NEG_SAT = 16'h8000;
    localparam logic [15:0] POS_SAT = 16'h7FFF;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_idx;
    logic [DW-1:0] in_act;
    logic [DW-1:0] in_err;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [DW-1:0] out_weight;
    logic [DW-1:0] out_bias;
    logic          busy;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_weight;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_w [NW];

    hidden_layer_backprop #(
        .DATA_W    (DW),
        .N_WEIGHTS (NW),
        .LR_SHIFT  (12),
        .CLIP_MAX  (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_act     (in_act),
        .in_err     (in_err),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_weight (out_weight),
        .out_bias   (out_bias),
        .busy       (busy),
        .rd_idx     (rd_idx),
        .rd_weight  (rd_weight)
    );

    always #50 clk = ~clk;

    // Presents one sample for one cycle and waits (bounded) for the result; lat = -1 on timeout.
    task automatic do_txn(input logic [IW-1:0] idx, input logic [15:0] act, input logic [15:0] err,
                          input logic last, output int lat);
        @(negedge clk);
        in_idx = idx; in_act = act; in_err = err; in_last = last; in_valid = 1'b1; rd_idx = idx;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_act = '0; in_err = '0; in_last = 1'b0;
        out_ready = 1'b1; rd_idx = '0;
        for (int i = 0; i < NW; i++) exp_w[i] = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if ({out_idx, out_weight, out_bias} !== 36'h0) begin
            bad++; $display("FAIL reset_outputs got idx=%h w=%h b=%h want all 0", out_idx, out_weight, out_bias);
        end
        for (int i = 0; i < NW; i++) begin
            rd_idx = 4'(i); #1;
            total++; if (rd_weight !== 16'h0000) begin bad++; $display("FAIL reset_rd_weight[%0d] got=%h want=0000", i, rd_weight); end
        end
    endtask

    task automatic test_basic();
        int lat;
        do_txn(4'd3, 16'h0100, 16'h0100, 1'b0, lat);
        exp_w[3] = 16'hFFF0;
        total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lat); end
        total++; if (out_idx !== 4'd3) begin bad++; $display("FAIL basic_idx got=%0d want=3", out_idx); end
        total++; if (out_weight !== 16'hFFF0) begin bad++; $display("FAIL basic_weight got=%h want=FFF0", out_weight); end
        total++; if (out_bias !== 16'h0000) begin bad++; $display("FAIL basic_bias got=%h want=0000", out_bias); end
        total++; if (rd_weight !== 16'hFFF0) begin bad++; $display("FAIL basic_rd_weight got=%h want=FFF0", rd_weight); end
    endtask

    task automatic test_last();
        int lat;
        do_txn(4'd5, 16'h0100, 16'h0100, 1'b1, lat);
        exp_w[5] = 16'hFFF0;
        total++; if (lat !== 3) begin bad++; $display("FAIL last_latency got=%0d want=3", lat); end
        total++; if (out_weight !== 16'hFFF0) begin bad++; $display("FAIL last_weight got=%h want=FFF0", out_weight); end
        total++; if (out_bias !== 16'hFFF0) begin bad++; $display("FAIL last_bias got=%h want=FFF0", out_bias); end
    endtask

    task automatic test_saturate();
        int lat;
        do_txn(4'd0, 16'h7FFF, 16'h7FFF, 1'b0, lat);
        exp_w[0] = NEG_SAT;
        total++; if (lat !== 3) begin bad++; $display("FAIL sat_neg_latency got=%0d want=3", lat); end
        total++; if (out_weight !== NEG_SAT) begin bad++; $display("FAIL sat_neg_weight got=%h want=%h", out_weight, NEG_SAT); end
        total++; if (out_bias !== 16'hFFF0) begin bad++; $display("FAIL sat_neg_bias got=%h want=FFF0", out_bias); end
        do_txn(4'd1, 16'h7FFF, 16'h8000, 1'b0, lat);
        exp_w[1] = POS_SAT;
        total++; if (out_weight !== POS_SAT) begin bad++; $display("FAIL sat_pos_weight got=%h want=%h", out_weight, POS_SAT); end
        total++; if (rd_weight !== POS_SAT) begin bad++; $display("FAIL sat_pos_rd_weight got=%h want=%h", rd_weight, POS_SAT); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        // 3.0 * -1.0 = -3.0 -> step -48 -> weight +0x0030
        do_txn(4'd7, 16'h0300, 16'hFF00, 1'b0, lat);
        exp_w[7] = 16'h0030;
        total++; if (lat !== 3) begin bad++; $display("FAIL bp_latency got=%0d want=3", lat); end
        in_idx = 4'd8; in_act = 16'h0100; in_err = 16'h0100; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_weight !== 16'h0030 || out_idx !== 4'd7) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b w=%h idx=%0d want v=1 rdy=0 w=0030 idx=7",
                         i, out_valid, in_ready, out_weight, out_idx);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_back_to_idle got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_second_accept got busy=%b want=1", busy); end
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        exp_w[8] = 16'hFFF0;
        total++; if (lat !== 3) begin bad++; $display("FAIL bp_second_latency got=%0d want=3", lat); end
        total++;
        if (out_idx !== 4'd8 || out_weight !== 16'hFFF0) begin
            bad++; $display("FAIL bp_second_result got idx=%0d w=%h want idx=8 w=FFF0", out_idx, out_weight);
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        do_txn(4'd11, 16'h0100, 16'h0200, 1'b0, lat);
        exp_w[11] = 16'hFFE0;
        total++; if (out_weight !== 16'hFFE0) begin bad++; $display("FAIL top_idx_weight got=%h want=FFE0", out_weight); end
        do_txn(4'd12, 16'h0100, 16'h0100, 1'b1, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL oor_latency got=%0d want=3", lat); end
        total++; if (out_idx !== 4'd12) begin bad++; $display("FAIL oor_idx got=%0d want=12", out_idx); end
        total++; if (out_weight !== 16'h0000) begin bad++; $display("FAIL oor_weight got=%h want=0000", out_weight); end
        total++; if (out_bias !== 16'hFFE0) begin bad++; $display("FAIL oor_bias got=%h want=FFE0", out_bias); end
        for (int i = 0; i < NW; i++) begin
            rd_idx = 4'(i); #1;
            total++;
            if (rd_weight !== exp_w[i]) begin bad++; $display("FAIL oor_store[%0d] got=%h want=%h", i, rd_weight, exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic saw_valid;
        @(negedge clk);
        in_idx = 4'd2; in_act = 16'h0100; in_err = 16'h0100; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_in_upd got busy=%b want=1", busy); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL mid_no_result got=%b want=0", saw_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
        for (int i = 0; i < NW; i++) begin
            rd_idx = 4'(i); #1;
            total++; if (rd_weight !== 16'h0000) begin bad++; $display("FAIL mid_store[%0d] got=%h want=0000", i, rd_weight); end
            exp_w[i] = 16'h0000;
        end
        do_txn(4'd3, 16'h0100, 16'h0100, 1'b0, lat);
        total++;
        if (lat !== 3 || out_weight !== 16'hFFF0 || out_bias !== 16'h0000) begin
            bad++; $display("FAIL mid_after lat=%0d w=%h b=%h want lat=3 w=FFF0 b=0000", lat, out_weight, out_bias);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last();
        test_saturate();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
